art_msg_sequencer: RTL
======================

Name: art_msg_sequencer

Overview:
- Sequences a short glyph message onto the 8 dedicated output pins (7-segment plus DP) of the silicon-art tile, so the die shows a visible pattern as well as carrying its GDS art.
- Holds an 8-entry glyph buffer, a tick prescaler and a small control register, all written through a valid/ready config port driven from ui_in/uio_in by the top level.
- A state machine steps through the buffer at the programmed rate, with optional blank gaps between glyphs and optional looping.

Parameters:
- PRE_SHIFT, 16, fixed power-of-two prescale; tick period = (reload+1) << PRE_SHIFT cycles; benches override it to 0.
- MSG_LEN, 8, glyph buffer depth; must be a power of two, maximum 8.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous reset, active-high.
- ena  input  1  tile enable; when low, the prescaler freezes and state holds.
- run  input  1  level; high starts/continues display, low aborts to IDLE.
- cfg_valid  input  1  config write request.
- cfg_ready  output  1  config write accepted when valid&ready.
- cfg_addr  input  2  0=reload, 1=glyph write, 2=control, 3=reserved (accepted, ignored).
- cfg_data  input  8  write data.
- seg_out  output  8  {dp,g,f,e,d,c,b,a}, active-high.
- char_idx  output  3  index of the glyph currently shown.
- done  output  1  one-cycle pulse when a non-looping message completes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; seg_out=0; char_idx=0; done=0.
  - reload=8'hFF; ctrl = {gap_en=0, loop=1, last=MSG_LEN-1}.
  - All glyph entries=4'hF (blank); prescaler count=0.
- Config registers:
  - addr0: reload=cfg_data.
  - addr1: glyph[cfg_data[6:4]]=cfg_data[3:0]; cfg_data[7] is ignored.
  - addr2: last=cfg_data[2:0], loop=cfg_data[3], gap_en=cfg_data[4].
  - last > MSG_LEN-1 saturates to MSG_LEN-1.
- Config handshake:
  - cfg_ready=1 only in IDLE and DONE, decoded from registered state; it is therefore 1 during and right after reset.
  - A write takes effect on the accepting edge. No write is lost or applied while cfg_ready=0.
  - cfg_valid may be held indefinitely without harm.
- Prescaler:
  - Down-counter loaded with ((reload+1)<<PRE_SHIFT)-1 on entry to SHOW or GAP.
  - tick=1 for one cycle when the count reaches 0 while ena=1, then it reloads.
  - Counter holds while ena=0.
- State machine:
  - IDLE: seg_out=0. run=1 and ena=1 -> SHOW, char_idx=0, prescaler loaded.
  - SHOW: seg_out=glyph_decode(glyph[char_idx]), registered, so it is valid the cycle after entry. On tick: gap_en=1 -> GAP; otherwise ADVANCE.
  - GAP: seg_out=0 for one tick period, then ADVANCE.
  - ADVANCE (a transition, not a state):
    - char_idx<last -> char_idx+1, SHOW.
    - char_idx==last and loop=1 -> char_idx=0, SHOW.
    - char_idx==last and loop=0 -> DONE, done pulses that cycle.
  - DONE: seg_out=0, char_idx holds last. run=0 -> IDLE. Holding run=1 does not restart.
- Abort: run=0 in SHOW/GAP -> IDLE on the next edge, seg_out=0, char_idx=0, no done pulse.
- Simultaneous events: run=0 wins over tick. A tick on the final glyph with run=0 produces no done.
- last=0: a single glyph is shown; with loop=1 it stays lit and keeps re-entering SHOW.
- Glyph decode: codes 0-9 are digits, A=H, B=I, C=L, D=dash, E=dp-only, F=blank.
- rst mid-message returns to full reset values, including the config registers.

Decomposition:
- Package art_pkg holds:
  - the state enum {IDLE, SHOW, GAP, DONE};
  - cfg address constants ADDR_RELOAD, ADDR_GLYPH, ADDR_CTRL;
  - ctrl bit positions;
  - the glyph code constants and the GLYPH_BLANK reset value.
- One combinational sub-module, art_glyph_decode (4-bit code -> 8-bit segments), shared with any future display block.
- The prescaler stays inline.

Test Plan:
- Reset: assert rst for 2 cycles -> seg_out=0, char_idx=0, done=0, cfg_ready=1.
- Write flow (PRE_SHIFT=0):
  - Stimulus: reload=3, glyphs 0..2 = 1,2,3, ctrl=0x02 (last=2, loop=0, no gap), then run=1.
  - Required: seg_out shows "1","2","3" for 4 cycles each, then DONE with a single done pulse and seg_out=0.
- Gap and loop:
  - Stimulus: ctrl=0x19 (last=1, loop=1, gap_en=1), reload=1.
  - Required: repeating glyph0(2 cycles), blank(2), glyph1(2), blank(2); done is never asserted.
- Handshake:
  - Stimulus: cfg_valid=1 with addr1 during SHOW.
  - Required: cfg_ready=0 and the glyph is unchanged; once run=0 and state is IDLE, the write is accepted and the glyph updated.
- Abort and freeze:
  - Stimulus: drop run mid-SHOW.
  - Required: IDLE next cycle, char_idx=0, no done.
  - Stimulus: ena=0 for 10 cycles mid-glyph.
  - Required: the glyph display is extended by exactly 10 cycles.
- Saturation and reset:
  - Stimulus: ctrl last written as 7 with MSG_LEN=4.
  - Required: sequence wraps after index 3.
  - Stimulus: rst mid-message.
  - Required: all registers return to reset values.

Source files
------------

// File: rtl/art_pkg.sv
// ----------------------------------------------------------------------------
// art_pkg
// Shared types and constants for the silicon-art message sequencer:
//   - sequencer state encoding
//   - config port address map and control-register bit positions
//   - glyph codes understood by art_glyph_decode
// ----------------------------------------------------------------------------
package art_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_RELOAD = 2'd0;
   localparam logic [1:0] ADDR_GLYPH  = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;

   localparam int CTRL_LAST_LSB = 0;
   localparam int CTRL_LOOP_BIT = 3;
   localparam int CTRL_GAP_BIT  = 4;

   // Glyph writes carry the buffer index in bits [6:4] and the code in [3:0].
   localparam int GLYPH_IDX_LSB = 4;

   localparam logic [3:0] GLYPH_H     = 4'hA;
   localparam logic [3:0] GLYPH_I     = 4'hB;
   localparam logic [3:0] GLYPH_L     = 4'hC;
   localparam logic [3:0] GLYPH_DASH  = 4'hD;
   localparam logic [3:0] GLYPH_DP    = 4'hE;
   localparam logic [3:0] GLYPH_BLANK = 4'hF;

endpackage

// File: rtl/art_glyph_decode.sv
// ----------------------------------------------------------------------------
// art_glyph_decode
// Combinational 4-bit glyph code to 7-segment + DP pattern.
// Ports:
//   code  in   4  glyph code (0-9 digits, A=H, B=I, C=L, D=dash, E=dp, F=blank)
//   seg   out  8  {dp,g,f,e,d,c,b,a}, active-high
// ----------------------------------------------------------------------------
module art_glyph_decode
   import art_pkg::*;
(
   input  logic [3:0] code,
   output logic [7:0] seg
);

   always_comb begin
      seg = 8'h00;
      case (code)
         4'h0:        seg = 8'h3F;
         4'h1:        seg = 8'h06;
         4'h2:        seg = 8'h5B;
         4'h3:        seg = 8'h4F;
         4'h4:        seg = 8'h66;
         4'h5:        seg = 8'h6D;
         4'h6:        seg = 8'h7D;
         4'h7:        seg = 8'h07;
         4'h8:        seg = 8'h7F;
         4'h9:        seg = 8'h6F;
         GLYPH_H:     seg = 8'h76;
         GLYPH_I:     seg = 8'h30;   // left-hand bar, so it differs from "1"
         GLYPH_L:     seg = 8'h38;
         GLYPH_DASH:  seg = 8'h40;
         GLYPH_DP:    seg = 8'h80;
         default:     seg = 8'h00;   // GLYPH_BLANK
      endcase
   end

endmodule

// File: rtl/art_msg_sequencer.sv
// ----------------------------------------------------------------------------
// art_msg_sequencer
// Steps a short glyph message onto the tile's 7-segment + DP pins.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ena             tile enable; low freezes the prescaler and holds state
//   run             level: high starts/continues display, low aborts to IDLE
//   cfg_valid/ready config write handshake (ready only in IDLE and DONE)
//   cfg_addr/data   0=reload, 1=glyph {idx[6:4],code[3:0]}, 2=ctrl, 3=ignored
//   seg_out         {dp,g,f,e,d,c,b,a}, registered
//   char_idx        index of the glyph currently shown
//   done            one-cycle pulse when a non-looping message completes
// ----------------------------------------------------------------------------
module art_msg_sequencer
   import art_pkg::*;
#(
   parameter int PRE_SHIFT = 16,
   parameter int MSG_LEN   = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       run,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic [1:0] cfg_addr,
   input  logic [7:0] cfg_data,
   output logic [7:0] seg_out,
   output logic [2:0] char_idx,
   output logic       done
);

   localparam int         IDX_W    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
   localparam int         CNT_W    = 9 + PRE_SHIFT;
   localparam logic [2:0] LAST_MAX = 3'(MSG_LEN - 1);

   state_t           state, state_nx;
   logic [7:0]       reload;
   logic [2:0]       last;
   logic             loop_en, gap_en;
   logic [3:0]       glyph [MSG_LEN];
   logic [CNT_W-1:0] cnt, cnt_load;
   logic             active, tick, load_cnt, done_nx, cfg_wr;
   logic [2:0]       idx_nx, last_wr;
   logic [3:0]       code_nx;
   logic [7:0]       seg_dec, seg_nx;

   assign cfg_ready = (state == IDLE) || (state == DONE);
   assign cfg_wr    = cfg_valid && cfg_ready;
   assign last_wr   = (cfg_data[2:0] > LAST_MAX) ? LAST_MAX : cfg_data[2:0];

   // Full tick period is (reload+1) << PRE_SHIFT cycles; the counter runs N-1..0.
   assign cnt_load = ((CNT_W'(reload) + CNT_W'(1)) << PRE_SHIFT) - CNT_W'(1);
   assign active   = (state == SHOW) || (state == GAP);
   assign tick     = active && ena && (cnt == '0);

   // Decode the glyph for the next state so seg_out lines up with state.
   assign code_nx = glyph[idx_nx[IDX_W-1:0]];

   art_glyph_decode u_decode (
      .code (code_nx),
      .seg  (seg_dec)
   );

   assign seg_nx = (state_nx == SHOW) ? seg_dec : 8'h00;

   always_comb begin
      state_nx = state;
      idx_nx   = char_idx;
      load_cnt = 1'b0;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (run && ena) begin
               state_nx = SHOW;
               idx_nx   = 3'd0;
               load_cnt = 1'b1;
            end
         end
         SHOW, GAP: begin
            // Abort has priority over any tick in the same cycle.
            if (!run) begin
               state_nx = IDLE;
               idx_nx   = 3'd0;
            end else if (tick) begin
               if ((state == SHOW) && gap_en) begin
                  state_nx = GAP;
                  load_cnt = 1'b1;
               end else if (char_idx < last) begin
                  state_nx = SHOW;
                  idx_nx   = char_idx + 3'd1;
                  load_cnt = 1'b1;
               end else if (loop_en) begin
                  state_nx = SHOW;
                  idx_nx   = 3'd0;
                  load_cnt = 1'b1;
               end else begin
                  state_nx = DONE;
                  done_nx  = 1'b1;
               end
            end
         end
         DONE: begin
            if (!run) begin
               state_nx = IDLE;
               idx_nx   = 3'd0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         char_idx <= 3'd0;
         seg_out  <= 8'h00;
         done     <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_nx;
         char_idx <= idx_nx;
         seg_out  <= seg_nx;
         done     <= done_nx;
         if (load_cnt) begin
            cnt <= cnt_load;
         end else if (active && ena && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reload  <= 8'hFF;
         last    <= LAST_MAX;
         loop_en <= 1'b1;
         gap_en  <= 1'b0;
         for (int i = 0; i < MSG_LEN; i++) begin
            glyph[i] <= GLYPH_BLANK;
         end
      end else if (cfg_wr) begin
         case (cfg_addr)
            ADDR_RELOAD: reload <= cfg_data;
            ADDR_GLYPH:  glyph[cfg_data[GLYPH_IDX_LSB +: IDX_W]] <= cfg_data[3:0];
            ADDR_CTRL: begin
               last    <= last_wr;
               loop_en <= cfg_data[CTRL_LOOP_BIT];
               gap_en  <= cfg_data[CTRL_GAP_BIT];
            end
            default: ;
         endcase
      end
   end

endmodule
